// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: decoded operation and controller state.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_MUL,
    OP_ILL
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } alu_state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Shift ops are the only non-multiply ops that may need the iterative path
  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode: aluop/funct3/funct7/mext -> operation.
// ALU_MC_MUL_EN enables decode of MUL (aluop 10, funct3 000, mext 1).
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       mext,
  output alu_op_e    op
);

  // Decode table; anything not listed is illegal
  always_comb begin
    op = OP_ILL;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        if (mext) begin
`ifdef ALU_MC_MUL_EN
          if (funct3 == 3'b000) op = OP_MUL;
`endif
        end else begin
          case (funct3)
            3'b000:  op = funct7 ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ILL;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops finish in one
// cycle; shifts iterate SHIFT_STEP bits per cycle. ALU_MC_MUL_EN adds an
// iterative shift-add multiplier (one bit per cycle).
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic            mext,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  alu_state_e      state, state_d;
  alu_op_e         op_dec, op_q;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
`ifdef ALU_MC_MUL_EN
  logic [XLEN-1:0] mcand, mplier;
`endif

  logic [SW-1:0]   shamt_c;
  logic            accept_c;
  logic            needs_busy_c;
  logic [XLEN-1:0] alu_res_c, step_res_c, res_fin_c;
  logic [CW-1:0]   step_amt_c, cnt_rem_c;

  alu_decode u_decode (
    .aluop  (aluop),
    .funct3 (funct3),
    .funct7 (funct7),
    .mext   (mext),
    .op     (op_dec)
  );

  assign shamt_c      = op_b[SW-1:0];
  assign accept_c     = in_valid && (state == S_IDLE);
  assign needs_busy_c = (is_shift(op_dec) && (shamt_c != '0)) || (op_dec == OP_MUL);

  // Single-cycle result; shifts with shamt 0 pass op_a through
  always_comb begin
    alu_res_c = '0;
    case (op_dec)
      OP_ADD:  alu_res_c = op_a + op_b;
      OP_SUB:  alu_res_c = op_a - op_b;
      OP_SLT:  alu_res_c = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res_c = XLEN'(op_a < op_b);
      OP_XOR:  alu_res_c = op_a ^ op_b;
      OP_OR:   alu_res_c = op_a | op_b;
      OP_AND:  alu_res_c = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA: alu_res_c = op_a;
      default: alu_res_c = '0;
    endcase
  end

  // One iteration of the BUSY datapath; last shift step may be partial
  always_comb begin
    step_amt_c = (cnt < STEP) ? cnt : STEP;
    cnt_rem_c  = cnt - step_amt_c;
    step_res_c = acc;
    case (op_q)
      OP_SLL: step_res_c = acc << step_amt_c;
      OP_SRL: step_res_c = acc >> step_amt_c;
      OP_SRA: step_res_c = XLEN'($signed(acc) >>> step_amt_c);
`ifdef ALU_MC_MUL_EN
      OP_MUL: begin
        step_res_c = acc + (mplier[0] ? mcand : '0);
        cnt_rem_c  = cnt - CW'(1);
      end
`endif
      default: step_res_c = acc;
    endcase
  end

  assign res_fin_c = (state == S_BUSY) ? step_res_c : alu_res_c;

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept_c) state_d = needs_busy_c ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_rem_c == '0) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
      op_q      <= OP_ADD;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_MC_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      in_ready <= (state_d == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            op_q <= op_dec;
            acc  <= op_a;
            cnt  <= CW'(shamt_c);
`ifdef ALU_MC_MUL_EN
            if (op_dec == OP_MUL) begin
              acc    <= '0;
              cnt    <= CW'(XLEN);
              mcand  <= op_a;
              mplier <= op_b;
            end
`endif
          end
        end
        S_BUSY: begin
          acc <= step_res_c;
          cnt <= cnt_rem_c;
`ifdef ALU_MC_MUL_EN
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`endif
        end
        default: ;
      endcase
      if ((state != S_DONE) && (state_d == S_DONE)) begin
        out_valid <= 1'b1;
        result    <= res_fin_c;
        zero      <= (res_fin_c == '0);
        err       <= (state == S_IDLE) && (op_dec == OP_ILL);
      end else if ((state == S_DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random ops against a
// behavioural model of the ALU (result, err, latency, handshake behaviour).
module tb_alu_mc;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      aluop = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic            funct7 = 1'b0;
  logic            mext = 1'b0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7    (funct7),
    .mext      (mext),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written straight from the instruction semantics
  function automatic void model(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                input logic me, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    int unsigned sh;
    sh  = b % XLEN;
    r   = '0;
    e   = 1'b0;
    lat = 1;
    if (aop == 2'b00) r = a + b;
    else if (aop == 2'b01) r = a - b;
    else if (aop == 2'b11) e = 1'b1;
    else if (me) begin
`ifdef ALU_MC_MUL_EN
      if (f3 == 3'b000) begin
        r   = a * b;
        lat = XLEN + 1;
      end else e = 1'b1;
`else
      e = 1'b1;
`endif
    end else begin
      case (f3)
        3'd0: r = f7 ? a - b : a + b;
        3'd1: begin r = a << sh; lat = 1 + int'((sh + STEP - 1) / STEP); end
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          r   = f7 ? 32'($signed(a) >>> sh) : a >> sh;
          lat = 1 + int'((sh + STEP - 1) / STEP);
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  // Issue one op, hold out_ready low for 'hold' cycles, then drain it
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f7, input logic me, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          cyc;
    logic        rdy_seen;
    model(aop, f3, f7, me, a, b, er, ee, lat);
    @(negedge clk);
    chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'(1));
    aluop = aop; funct3 = f3; funct7 = f7; mext = me; op_a = a; op_b = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 200) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      cyc++;
    end
    rdy_seen |= in_ready;
    chk({tag, ":latency"}, 64'(cyc), 64'(lat));
    chk({tag, ":result"}, 64'(result), 64'(er));
    chk({tag, ":zero"}, 64'(zero), 64'(er == 32'd0));
    chk({tag, ":err"}, 64'(err), 64'(ee));
    chk({tag, ":in_ready_busy"}, 64'(rdy_seen), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
      chk({tag, ":hold_result"}, 64'(result), 64'(er));
      chk({tag, ":hold_err"}, 64'(err), 64'(ee));
      chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ":drained"}, 64'(out_valid), 64'(0));
    chk({tag, ":in_ready_after"}, 64'(in_ready), 64'(1));
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic seen;
    logic [1:0] aop;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst:out_valid", 64'(out_valid), 64'(0));
    chk("rst:result", 64'(result), 64'(0));
    chk("rst:zero", 64'(zero), 64'(1));
    chk("rst:err", 64'(err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:in_ready", 64'(in_ready), 64'(1));

    // Directed cases
    run_op("add_wrap", 2'b00, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub", 2'b01, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 0);
    run_op("sra4", 2'b10, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 0);
    run_op("slt_bp", 2'b10, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 3);
    run_op("sltu", 2'b10, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("illegal11", 2'b11, 3'd4, 1'b0, 1'b0, 32'h1234_5678, 32'd9, 0);
    run_op("mext", 2'b10, 3'd0, 1'b0, 1'b1, 32'd7, 32'd6, 0);
    run_op("sll0", 2'b10, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd32, 0);
    run_op("sll31", 2'b10, 3'd1, 1'b0, 1'b0, 32'h0000_0003, 32'd31, 2);
    run_op("srl31", 2'b10, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 0);
`ifdef ALU_MC_MUL_EN
    run_op("mul42", 2'b10, 3'd0, 1'b0, 1'b1, 32'd7, 32'd6, 0);
    run_op("mul_neg", 2'b10, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1);
`endif

    // Reset in the middle of a long shift aborts it silently
    @(negedge clk);
    aluop = 2'b10; funct3 = 3'd1; funct7 = 1'b0; mext = 1'b0;
    op_a = 32'h0000_0001; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst:out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst:result", 64'(result), 64'(0));
    chk("mid_rst:zero", 64'(zero), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst:in_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("mid_rst:no_stale", 64'(seen), 64'(0));
    out_ready = 1'b0;

    // Random operations
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       aop = 2'b00;
        1:       aop = 2'b01;
        2:       aop = 2'b11;
        default: aop = 2'b10;
      endcase
      run_op("rand", aop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), pick_operand(), pick_operand(),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
